// File: rtl/ext_btn_gpio.sv
// Memory-mapped input GPIO: synchronised, debounced push-buttons with sticky
// rise/fall flags, W1C clearing and a maskable level interrupt.
module ext_btn_gpio #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      data_in,
  input  logic             rd_strobe,
  input  logic [3:0]       wr_strobe,
  output logic [31:0]      data_out,
  input  logic [N_BTN-1:0] btn_in,
  output logic             irq
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     LO_MASK = 16'((32'd1 << N_BTN) - 32'd1);
  localparam logic [31:0]     EN_MASK = {LO_MASK, LO_MASK};

  localparam logic [1:0] A_STATE = 2'd0;
  localparam logic [1:0] A_RISE  = 2'd1;
  localparam logic [1:0] A_FALL  = 2'd2;
  localparam logic [1:0] A_EN    = 2'd3;

  logic [N_BTN-1:0] r_sync1, r_sync2, r_stable;
  logic [CW-1:0]    r_cnt [N_BTN];
  logic [N_BTN-1:0] r_rise, r_fall, r_en_rise, r_en_fall;
  logic [31:0]      r_data_out;
  logic             r_irq;

  logic [N_BTN-1:0] w_toggle;
  logic [N_BTN-1:0] w_rise_clr, w_fall_clr;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic [1:0]       w_sel;
  logic             w_unused_bits;

  assign w_wr          = |wr_strobe;
  assign w_sel         = addr[3:2];
  assign w_unused_bits = ^{addr[31:4], addr[1:0], data_in & ~EN_MASK};

  // Stable flips on the cycle the mismatch count would reach DEBOUNCE_CYCLES.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < N_BTN; i++)
      w_toggle[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= btn_in;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_toggle;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_stable[i] || w_toggle[i]) r_cnt[i] <= '0;
        else                                          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise_clr = (w_wr && w_sel == A_RISE) ? data_in[N_BTN-1:0] : '0;
  assign w_fall_clr = (w_wr && w_sel == A_FALL) ? data_in[N_BTN-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      A_STATE: w_rdata[N_BTN-1:0] = r_stable;
      A_RISE:  w_rdata[N_BTN-1:0] = r_rise;
      A_FALL:  w_rdata[N_BTN-1:0] = r_fall;
      A_EN: begin
        w_rdata[N_BTN-1:0]     = r_en_rise;
        w_rdata[N_BTN+15:16]   = r_en_fall;
      end
      default: w_rdata = '0;
    endcase
  end

  // New edge events are OR-ed in after the clear so a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise     <= '0;
      r_fall     <= '0;
      r_en_rise  <= '0;
      r_en_fall  <= '0;
      r_data_out <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_rise <= (r_rise & ~w_rise_clr) | (w_toggle & ~r_stable);
      r_fall <= (r_fall & ~w_fall_clr) | (w_toggle & r_stable);
      if (w_wr && w_sel == A_EN) begin
        r_en_rise <= data_in[N_BTN-1:0];
        r_en_fall <= data_in[N_BTN+15:16];
      end
      if (rd_strobe) r_data_out <= w_rdata;
      r_irq <= (|(r_rise & r_en_rise)) | (|(r_fall & r_en_fall));
    end
  end

  assign data_out = r_data_out;
  assign irq      = r_irq;

endmodule

// File: tb/tb_ext_btn_gpio.sv
// Bench for ext_btn_gpio: directed steps plus random traffic, every cycle
// compared with a cycle-level behavioural model of the register interface.
module tb_ext_btn_gpio;
  localparam int N  = 5;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr, data_in, data_out;
  logic          rd_strobe, irq;
  logic [3:0]    wr_strobe;
  logic [N-1:0]  btn_in;

  int errors = 0;
  int checks = 0;

  ext_btn_gpio #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .data_out(data_out),
    .btn_in(btn_in), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_enr, m_enf;
  logic [31:0]  m_dout;
  logic         m_irq;
  logic [N-1:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
    m_enr = '0; m_enf = '0; m_dout = '0; m_irq = 1'b0;
    hist.delete();
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] s);
    logic [31:0] v;
    v = '0;
    case (s)
      2'd0: v[N-1:0] = m_stable;
      2'd1: v[N-1:0] = m_rise;
      2'd2: v[N-1:0] = m_fall;
      default: begin v[N-1:0] = m_enr; v[N+15:16] = m_enf; end
    endcase
    return v;
  endfunction

  // An input is accepted once the last DC synchronised samples all disagree with stable.
  task automatic model_step();
    logic [N-1:0] tog, clr_r, clr_f;
    logic [31:0]  rv;
    logic         nirq, wr;
    if (rst) begin model_reset(); return; end
    hist.push_back(m_s2);
    if (hist.size() > DC) void'(hist.pop_front());
    tog = '0;
    if (hist.size() == DC)
      for (int i = 0; i < N; i++) begin
        bit all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        tog[i] = all_diff;
      end
    rv   = m_reg(addr[3:2]);
    nirq = (|(m_rise & m_enr)) | (|(m_fall & m_enf));
    wr   = |wr_strobe;
    clr_r = (wr && addr[3:2] == 2'd1) ? data_in[N-1:0] : '0;
    clr_f = (wr && addr[3:2] == 2'd2) ? data_in[N-1:0] : '0;
    m_rise = (m_rise & ~clr_r) | (tog & ~m_stable);
    m_fall = (m_fall & ~clr_f) | (tog & m_stable);
    if (wr && addr[3:2] == 2'd3) begin m_enr = data_in[N-1:0]; m_enf = data_in[N+15:16]; end
    if (rd_strobe) m_dout = rv;
    m_irq    = nirq;
    m_stable = m_stable ^ tog;
    m_s2     = m_s1;
    m_s1     = btn_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_data_out", data_out, m_dout);
    chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; data_in = d; wr_strobe = 4'hF; tick(); wr_strobe = 4'h0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; data_in = '0; rd_strobe = 1'b0; wr_strobe = '0; btn_in = '0;
    model_reset();
    ticks(2);
    rst = 1'b0;

    // Reset values of every register
    rd(32'h8000_0100); chk("rst_state",  data_out, 32'h0);
    rd(32'h8000_0104); chk("rst_rise",   data_out, 32'h0);
    rd(32'h8000_0108); chk("rst_fall",   data_out, 32'h0);
    rd(32'h8000_010C); chk("rst_irq_en", data_out, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    wr(32'h8000_0100, 32'hFFFF_FFFF);
    rd(32'h8000_0100); chk("state_ro", data_out, 32'h0);

    // Short glitch on btn2 is filtered
    btn_in = 5'b00100; ticks(3);
    btn_in = 5'b00000; ticks(10);
    rd(32'h0); chk("glitch_state", data_out, 32'h0);
    rd(32'h4); chk("glitch_rise",  data_out, 32'h0);
    rd(32'h8); chk("glitch_fall",  data_out, 32'h0);

    // btn0 press: stable after 2+4 edges, read one cycle after strobe
    btn_in = 5'b00001;
    addr = 32'h0; rd_strobe = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("state_not_yet", data_out, 32'h0);
      if (k == 7) chk("state_at_6",    data_out, 32'h1);
    end
    rd_strobe = 1'b0;
    rd(32'h4); chk("rise_btn0", data_out, 32'h1);
    wr(32'h4, 32'h1);
    btn_in = 5'b00000; ticks(8);
    wr(32'h8, 32'h1);
    rd(32'h8); chk("fall_cleared", data_out, 32'h0);

    // Rise interrupt
    wr(32'hC, 32'h0000_0001);
    rd(32'hC); chk("irq_en_rb", data_out, 32'h1);
    btn_in = 5'b00001;
    ticks(6); chk("irq_before", {31'd0, irq}, 32'h0);
    tick();   chk("irq_set",    {31'd0, irq}, 32'h1);
    wr(32'h4, 32'h1); chk("irq_lag", {31'd0, irq}, 32'h1);
    tick();           chk("irq_drop", {31'd0, irq}, 32'h0);
    rd(32'h4); chk("rise_w1c", data_out, 32'h0);
    btn_in = 5'b00000; ticks(8);
    rd(32'h8); chk("fall_btn0", data_out, 32'h1);
    chk("fall_no_irq", {31'd0, irq}, 32'h0);
    wr(32'h8, 32'h1);

    // W1C of RISE[3] on the very edge it is set: set wins
    btn_in = 5'b01000; ticks(5);
    wr(32'h4, 32'h8);
    rd(32'h4); chk("set_wins", data_out, 32'h8);
    wr(32'hC, 32'h8);
    tick(); chk("irq_bit3", {31'd0, irq}, 32'h1);
    rd(32'h4);

    // Async reset between edges, with btn4 held
    btn_in = 5'b10000;
    #4 rst = 1'b1;
    #1;
    model_reset();
    chk("async_dout", data_out, 32'h0);
    chk("async_irq",  {31'd0, irq}, 32'h0);
    ticks(2);
    rst = 1'b0;
    rd(32'h0); chk("post_rst_state", data_out, 32'h0);
    ticks(5);
    rd(32'h0); chk("post_rst_state6", data_out, 32'h10);
    rd(32'h4); chk("post_rst_rise",   data_out, 32'h10);

    // Random traffic against the model
    wr(32'h4, 32'h1F); wr(32'h8, 32'h1F);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) btn_in = N'($urandom);
      addr      = {26'd0, 2'($urandom_range(0, 3)), 2'd0};
      rd_strobe = 1'($urandom_range(0, 1));
      wr_strobe = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      data_in   = $urandom;
      tick();
    end
    rd_strobe = 1'b0; wr_strobe = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ext_btn_gpio.md
Name: ext_btn_gpio

Overview:
- Memory-mapped input GPIO responder for breadboard push-buttons and switches. It is the input-direction companion to the external LED output GPIO.
- Each input is synchronised, debounced, and edge-captured into sticky flags; an optional interrupt request is driven to the core.
- It sits on the same CPU data bus as the LED GPIO: word-addressed registers, single-cycle strobes, registered read data. Base address is 0x8000_0100.

Parameters:
- N_BTN, 5, number of button inputs (1..16).
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles an input must hold a new level before it is accepted (10 ms at 25 MHz). Must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- addr  input  32  byte address. Only addr[3:2] is decoded; the block is selected by the external decoder gating the strobes.
- data_in  input  32  write data.
- rd_strobe  input  1  one-cycle read request.
- wr_strobe  input  4  byte write strobes. Any bit set means a full-word write.
- data_out  output  32  registered read data.
- btn_in  input  N_BTN  raw asynchronous button levels, active high.
- irq  output  1  level interrupt request.

Behaviour:
- Reset: one clock and an async active-high rst. While rst is high, all of the following are 0 immediately:
  - sync flops, debounce counters, stable levels
  - RISE, FALL, IRQ_EN registers
  - data_out, irq
- Synchroniser: 2-flop per bit, giving btn_sync. Raw-to-sync latency is 2 cycles.
- Debounce, per bit, one counter of width clog2(DEBOUNCE_CYCLES):
  - If btn_sync == stable, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still mismatched, stable toggles and the counter clears.
  - Net effect: a clean level change appears in stable exactly DEBOUNCE_CYCLES cycles after btn_sync changes.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count; stable is unchanged.
- Edge capture (sticky):
  - A stable 0->1 transition sets RISE[i].
  - A stable 1->0 transition sets FALL[i].
- Register map (offset = addr[3:2]*4):
  - 0x0 STATE: RO, {0, stable}.
  - 0x4 RISE: W1C.
  - 0x8 FALL: W1C.
  - 0xC IRQ_EN: RW, bits [N_BTN-1:0] enable the rise interrupt, bits [N_BTN+15:16] enable the fall interrupt. Other bits read 0.
- Read:
  - On a cycle with rd_strobe=1, data_out <= the selected register at the next clk edge, so read data is valid the cycle after the strobe.
  - data_out holds its value when there is no strobe.
  - Unimplemented bits read 0.
  - Writes to STATE are ignored.
- Write: on a cycle with |wr_strobe=1, the W1C registers clear the bits written as 1, and IRQ_EN loads the masked data_in.
- Simultaneous set and W1C clear of the same bit in one cycle: the set wins and the bit stays 1.
- Simultaneous rd_strobe and wr_strobe: both are performed; the read returns the pre-write value.
- irq = |(RISE & IRQ_EN[N_BTN-1:0]) | |(FALL & IRQ_EN[N_BTN+15:16]). It is registered, so it asserts 1 cycle after the causing flag or enable update and deasserts 1 cycle after the flags are cleared.
- Reset asserted mid-debounce or mid-read aborts the operation. After release, stable=0, so an input already held high re-debounces and produces a RISE event.

Test Plan (bench uses DEBOUNCE_CYCLES=4, N_BTN=5):
- Reset, then read 0x0, 0x4, 0x8 and 0xC -> each returns 0x0000_0000 and irq=0. Assert rst asynchronously between clk edges -> outputs clear without waiting for a clock edge.
- Hold btn_in=5'b00001 steady -> STATE reads 0x1 starting exactly 2+4 cycles after the change; RISE reads 0x1. Read data appears the cycle after rd_strobe.
- Apply a 3-cycle pulse on btn_in[2] -> STATE, RISE and FALL stay 0.
- Write IRQ_EN=0x0000_0001, then press btn0 -> irq=1. Write 0x1 to RISE -> RISE=0 and irq drops 1 cycle later. Then release btn0 -> FALL=0x1 and irq stays 0 (fall not enabled).
- Issue a W1C of RISE bit 3 in the same cycle stable[3] rises -> RISE[3] reads 1.
- Hold btn4 high, assert rst for 2 cycles, then release -> STATE=0 immediately after reset; STATE=0x10 and RISE=0x10 after 6 cycles.
